// File: rtl/irq_pend_latch_pkg.sv
// irq_pend_latch_pkg
// Shared constants and helpers for the interrupt request capture stage.
//   N_REQ_DEF     : number of request lines (matches the 4-wide pEncoder4x2)
//   IDX_W         : width of a request index (ack_idx / encoder Q_out)
//   PRIO_TOP_IDX  : index of the highest-priority line; priority falls with index
//   idx_to_onehot : expands a request index into a one-hot bit vector
package irq_pend_latch_pkg;

    localparam int unsigned N_REQ_DEF    = 4;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned PRIO_TOP_IDX = N_REQ_DEF - 1;

    function automatic logic [N_REQ_DEF-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ_DEF-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/irq_pend_latch_sync_edge.sv
// irq_pend_latch_sync_edge
// One request line: SYNC_STAGES-deep flop synchroniser followed by a prev
// flop used for rising-edge detection.
//   clk       : sole clock
//   rst_n     : synchronous active-low reset
//   req_async : raw asynchronous request line
//   evt       : combinational event flag (rising edge or level, per EDGE_MODE)
module irq_pend_latch_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE_MODE   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_async,
    output logic evt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req_async};
        prev_d = sync_last;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // prev_q clears on reset, so a line held high through reset is reported
    // once after release.
    always_comb begin
        evt = EDGE_MODE ? (sync_last & ~prev_q) : sync_last;
    end

endmodule

// File: rtl/irq_pend_latch.sv
// irq_pend_latch
// Captures events on four asynchronous request lines into pending bits that
// the consumer clears by index. The masked pending vector feeds the
// pEncoder4x2 D_in, so its Q_out/v name the top outstanding request.
//   clk      : sole clock
//   rst_n    : synchronous active-low reset
//   req_in   : asynchronous request lines, bit 3 highest priority
//   mask     : 1 hides a bit from pend_out/any_pend (capture still happens)
//   ack      : clear pending bit ack_idx at this edge
//   ack_idx  : index to clear, normally the encoder Q_out
//   clr_ovf  : clear all sticky overflow bits
//   pend_out : registered pending & ~mask
//   any_pend : registered OR of the masked pending vector
//   ovf      : sticky, event arrived while that bit was already pending
module irq_pend_latch
    import irq_pend_latch_pkg::*;
#(
    parameter int unsigned N_REQ       = N_REQ_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE_MODE   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    input  logic             clr_ovf,
    output logic [N_REQ-1:0] pend_out,
    output logic             any_pend,
    output logic [N_REQ-1:0] ovf
);

    logic [N_REQ-1:0] evt;
    logic [N_REQ-1:0] ack_clr;
    logic [N_REQ-1:0] pend_q;
    logic [N_REQ-1:0] pend_d;
    logic [N_REQ-1:0] ovf_q;
    logic [N_REQ-1:0] ovf_d;
    logic [N_REQ-1:0] pend_out_q;
    logic [N_REQ-1:0] pend_out_d;
    logic             any_pend_q;
    logic             any_pend_d;

    for (genvar i = 0; i < N_REQ; i++) begin : g_line
        irq_pend_latch_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE)
        ) u_sync_edge (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_async (req_in[i]),
            .evt       (evt[i])
        );
    end

    always_comb begin
        ack_clr    = '0;
        if (ack) begin
            ack_clr = idx_to_onehot(ack_idx);
        end
        // A new event in the ack cycle re-arms the bit, so nothing is lost.
        pend_d     = evt | (pend_q & ~ack_clr);
        // A fresh overflow outranks clr_ovf in the same cycle.
        ovf_d      = (ovf_q & ~{N_REQ{clr_ovf}}) | (evt & pend_q & ~ack_clr);
        // Outputs come from pend_q, giving one extra edge after pend updates.
        pend_out_d = pend_q & ~mask;
        any_pend_d = |(pend_q & ~mask);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q     <= '0;
            ovf_q      <= '0;
            pend_out_q <= '0;
            any_pend_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            pend_out_q <= pend_out_d;
            any_pend_q <= any_pend_d;
        end
    end

    assign pend_out = pend_out_q;
    assign any_pend = any_pend_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_irq_pend_latch.sv
// tb_irq_pend_latch
// Directed bench for irq_pend_latch: each table row is one clock cycle of
// inputs plus the outputs expected just after that edge.
module tb_irq_pend_latch;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_idx;
    logic       clr_ovf;
    logic [3:0] pend_out;
    logic       any_pend;
    logic [3:0] ovf;

    int num_checks = 0;
    int num_fails  = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] msk;
        logic       ack;
        logic [1:0] idx;
        logic       clr;
        logic [3:0] exp_po;
        logic       exp_any;
        logic [3:0] exp_ovf;
    } vec_t;

    vec_t vecs[$];

    irq_pend_latch dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .mask     (mask),
        .ack      (ack),
        .ack_idx  (ack_idx),
        .clr_ovf  (clr_ovf),
        .pend_out (pend_out),
        .any_pend (any_pend),
        .ovf      (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // any_pend is always the OR of the expected masked pending vector.
    function automatic void addVec(input logic [3:0] req, input logic [3:0] msk,
                                   input logic a, input logic [1:0] idx,
                                   input logic clr, input logic [3:0] exp_po,
                                   input logic [3:0] exp_ovf);
        vec_t v;
        v.req     = req;
        v.msk     = msk;
        v.ack     = a;
        v.idx     = idx;
        v.clr     = clr;
        v.exp_po  = exp_po;
        v.exp_any = |exp_po;
        v.exp_ovf = exp_ovf;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, then step to just after the next edge.
    task automatic applyStimulus(input logic rst_v, input logic [3:0] req_v,
                                 input logic [3:0] mask_v, input logic ack_v,
                                 input logic [1:0] idx_v, input logic clr_v);
        rst_n   = rst_v;
        req_in  = req_v;
        mask    = mask_v;
        ack     = ack_v;
        ack_idx = idx_v;
        clr_ovf = clr_v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp_po,
                               input logic exp_any, input logic [3:0] exp_ovf);
        num_checks++;
        if (pend_out !== exp_po) begin
            num_fails++;
            $display("[TB] FAIL %s pend_out: got %b, expected %b", name, pend_out, exp_po);
        end
        num_checks++;
        if (any_pend !== exp_any) begin
            num_fails++;
            $display("[TB] FAIL %s any_pend: got %b, expected %b", name, any_pend, exp_any);
        end
        num_checks++;
        if (ovf !== exp_ovf) begin
            num_fails++;
            $display("[TB] FAIL %s ovf: got %b, expected %b", name, ovf, exp_ovf);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req_in  = 4'b0000;
        mask    = 4'b0000;
        ack     = 1'b0;
        ack_idx = 2'd0;
        clr_ovf = 1'b0;

        // Bit 3 rises and is held: visible three edges later, no repeats,
        // then acked by index 3.
        addVec(4'b1000, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b1000, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b1000, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b1000, 4'b0000, 0, 2'd0, 0, 4'b1000, 4'b0000);
        addVec(4'b1000, 4'b0000, 0, 2'd0, 0, 4'b1000, 4'b0000);
        addVec(4'b1000, 4'b0000, 1, 2'd3, 0, 4'b1000, 4'b0000);
        addVec(4'b1000, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        // Three lines at once, acked 3, 2, 0 with an idle cycle between.
        addVec(4'b1101, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b1101, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b1101, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b1101, 4'b0000, 0, 2'd0, 0, 4'b1101, 4'b0000);
        addVec(4'b1101, 4'b0000, 1, 2'd3, 0, 4'b1101, 4'b0000);
        addVec(4'b1101, 4'b0000, 0, 2'd0, 0, 4'b0101, 4'b0000);
        addVec(4'b1101, 4'b0000, 1, 2'd2, 0, 4'b0101, 4'b0000);
        addVec(4'b1101, 4'b0000, 0, 2'd0, 0, 4'b0001, 4'b0000);
        addVec(4'b1101, 4'b0000, 1, 2'd0, 0, 4'b0001, 4'b0000);
        addVec(4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        // Bit 1 pending, second rising edge without ack -> overflow.
        addVec(4'b0010, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0000);
        addVec(4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0000);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0000);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0000);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0010);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0010);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 1, 4'b0010, 4'b0000);
        // Same again but acked in the event cycle: bit stays, no overflow.
        addVec(4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0000);
        addVec(4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0000);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0000);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0000);
        addVec(4'b0010, 4'b0000, 1, 2'd1, 0, 4'b0010, 4'b0000);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0000);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0000);
        // Overflow and clr_ovf in the same cycle: overflow wins.
        addVec(4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0000);
        addVec(4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0000);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0000);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0000);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 1, 4'b0010, 4'b0010);
        addVec(4'b0010, 4'b0000, 1, 2'd1, 0, 4'b0010, 4'b0010);
        addVec(4'b0010, 4'b0000, 0, 2'd0, 1, 4'b0000, 4'b0000);
        addVec(4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        // Masked capture on bit 2, then unmask, then ack while masked.
        addVec(4'b0100, 4'b0100, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b0100, 4'b0100, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b0100, 4'b0100, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b0100, 4'b0100, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b0100, 4'b0100, 0, 2'd0, 0, 4'b0000, 4'b0000);
        addVec(4'b0100, 4'b0000, 0, 2'd0, 0, 4'b0100, 4'b0000);
        addVec(4'b0100, 4'b0100, 1, 2'd2, 0, 4'b0000, 4'b0000);
        addVec(4'b0100, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000);
        // Ack of a bit that is not pending.
        addVec(4'b0000, 4'b0000, 1, 2'd0, 0, 4'b0000, 4'b0000);

        $display("[TB] Starting irq_pend_latch directed test");

        // Reset state
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        checkOutput("reset", 4'b0000, 1'b0, 4'b0000);

        // Ten quiet cycles after release
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
            checkOutput($sformatf("idle%0d", i), 4'b0000, 1'b0, 4'b0000);
        end

        foreach (vecs[i]) begin
            applyStimulus(1'b1, vecs[i].req, vecs[i].msk, vecs[i].ack, vecs[i].idx, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_po, vecs[i].exp_any, vecs[i].exp_ovf);
        end

        // Mid-operation reset: pending 1010 is discarded, req_in[0] held
        // across reset is seen exactly once after release.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'b1010, 4'b0000, 1'b0, 2'd0, 1'b0);
        end
        applyStimulus(1'b1, 4'b1010, 4'b0000, 1'b0, 2'd0, 1'b0);
        checkOutput("pre_reset_a", 4'b1010, 1'b1, 4'b0000);
        applyStimulus(1'b1, 4'b1011, 4'b0000, 1'b0, 2'd0, 1'b0);
        checkOutput("pre_reset_b", 4'b1010, 1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1, 2'd3, 1'b0);
        checkOutput("mid_reset", 4'b0000, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
            checkOutput($sformatf("post_reset%0d", i), 4'b0000, 1'b0, 4'b0000);
        end
        applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
        checkOutput("post_reset_evt", 4'b0001, 1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
            checkOutput($sformatf("post_reset_hold%0d", i), 4'b0001, 1'b1, 4'b0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
